ioctl_download_driver: RTL and testbench
========================================

# ioctl_download_driver

Transmitter end of the MiSTer ioctl download interface. It drives `ioctl_download`, `ioctl_wr`, `ioctl_addr`, `ioctl_dout` and `ioctl_index` into a core's `emu` top, and honours the core's `ioctl_wait`. Bytes come from a valid/ready byte source, such as a ROM FIFO in the Verilator harness or an on-FPGA loader. The block replaces ad-hoc C++ poking of ioctl signals, so the same download sequence is reproducible in RTL benches.

## Interface
Parameters:
- `ADDR_WIDTH`, 25: width of `ioctl_addr` and `length`.
- `LEAD_CYCLES`, 4: cycles `ioctl_download` is high before the first fetch (≥1).
- `GAP_CYCLES`, 2: cycles after each `ioctl_wr` pulse before the next fetch (≥1).
- `TRAIL_CYCLES`, 4: cycles `ioctl_download` stays high after the last write (≥1).

Ports:
- `clk_sys` in, 1: sole clock.
- `reset` in, 1: synchronous, active-high reset.
- `start` in, 1: begin a download; sampled only in IDLE.
- `index` in, 8: latched at start and driven on `ioctl_index`.
- `length` in, ADDR_WIDTH: byte count, latched at start.
- `abort` in, 1: cancel the download from any state.
- `src_valid` in, 1: source byte is available.
- `src_data` in, 8: source byte.
- `src_ready` out, 1: driver accepts a byte this cycle.
- `ioctl_download` out, 1: download window is open.
- `ioctl_wr` out, 1: single-cycle write strobe.
- `ioctl_addr` out, ADDR_WIDTH: byte address of the current write.
- `ioctl_dout` out, 8: write data.
- `ioctl_index` out, 8: target index.
- `ioctl_wait` in, 1: core back-pressure.
- `busy` out, 1: driver is not IDLE.
- `done` out, 1: one-cycle pulse on normal completion.

## Operation
- FSM states: IDLE, LEAD, FETCH, ISSUE, GAP, TRAIL.
- IDLE:
  - `start` with `length`≠0 latches `index` and `length`, clears the byte counter, and moves to LEAD.
  - `start` with `length`=0 pulses `done` next cycle and stays in IDLE. `ioctl_download` never rises.
- LEAD: `ioctl_download`=1. Counts LEAD_CYCLES cycles, then moves to FETCH.
- FETCH:
  - `src_ready`=1 only in this state.
  - On `src_valid & src_ready`, latch `src_data` and move to ISSUE.
  - Otherwise wait indefinitely.
- ISSUE: if `ioctl_wait`=0 at the clock edge:
  - Register `ioctl_wr`=1, `ioctl_dout`=byte, `ioctl_addr`=counter.
  - Move to GAP.
  - If `ioctl_wait`=1, hold with no strobe.
- GAP:
  - `ioctl_wr` is high only in the first GAP cycle.
  - After GAP_CYCLES cycles, increment the counter.
  - Go to FETCH if counter < length, else TRAIL.
- TRAIL: after TRAIL_CYCLES cycles, drop `ioctl_download`, pulse `done`, return to IDLE.
- `abort` (any state except IDLE):
  - Next cycle: IDLE, `ioctl_download`=0, `ioctl_wr`=0.
  - No `done` pulse.
  - A byte already accepted is discarded.
- Priority:
  - `reset` > `abort` > `start`.
  - `abort` and `start` in the same IDLE cycle: `start` is ignored.
- Output holding:
  - `ioctl_addr`/`ioctl_dout` hold their last values between writes and after completion.
  - They are cleared only by reset.
  - `ioctl_index` holds its latched value until the next start.
- Widths:
  - Counter is ADDR_WIDTH bits.
  - `length` max is 2^ADDR_WIDTH−1.
  - The counter never wraps within a transfer; last address = length−1.

## Timing
- Reset values: all outputs 0, state IDLE.
- `start` at edge N → `ioctl_download`=1 and `busy`=1 from cycle N+1.
- First FETCH at cycle N+1+LEAD_CYCLES.
- With `src_valid`=1 and `ioctl_wait`=0:
  - One write per 2+GAP_CYCLES cycles.
  - `ioctl_wr` rises 2 cycles after FETCH is entered.
- `ioctl_wait` asserted in ISSUE delays the strobe cycle-for-cycle.
- `ioctl_wait` while in FETCH/GAP has no effect; it is sampled only in ISSUE.
- `done` is asserted in the cycle `ioctl_download` first reads 0. `busy` falls in the same cycle.
- `ioctl_wr` is never high unless `ioctl_download` is high.

## Structure
- Shared package `ioctl_pkg`:
  - State enum `ioctl_drv_state_t`.
  - Default `IOCTL_ADDR_WIDTH`=25.
  - Index constants, e.g. `IOCTL_IDX_ROM`=0.
- One sub-module, `ioctl_cycle_counter`: a loadable down-counter shared by LEAD/GAP/TRAIL, width clog2(max(LEAD,GAP,TRAIL))+1.
- All outputs registered.

## Test plan
- Basic transfer:
  - Stimulus: `length`=3, `index`=0x01, bytes A5,5A,FF, `src_valid` always 1, `ioctl_wait`=0, defaults.
  - Response: 3 single-cycle strobes at addr 0,1,2 with matching data, 4 cycles apart; `done` once; `ioctl_download` high for exactly 4+3·4+4 cycles.
- Back-pressure:
  - Stimulus: hold `ioctl_wait`=1 for 10 cycles during the second ISSUE.
  - Response: the second strobe is delayed exactly 10 cycles; addr/data unchanged; no duplicate strobe.
- Source stall:
  - Stimulus: `src_valid` low for 7 cycles in FETCH.
  - Response: `src_ready` stays 1, no strobe, transfer resumes and completes with correct addresses.
- Zero length:
  - Stimulus: `start` with `length`=0.
  - Response: `done` pulse at N+1; `ioctl_download` never 1; `busy` stays 0.
- Abort:
  - Stimulus: `abort` in the GAP after addr 1 of a 5-byte transfer.
  - Response: `ioctl_download`=0 next cycle, no `done`, no further strobes; a new `start` restarts at addr 0.
- Reset mid-transfer:
  - Stimulus: `reset` during LEAD and during ISSUE.
  - Response: all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/ioctl_pkg.sv
// Shared state type, widths and index constants for the ioctl driver.
package ioctl_pkg;

    localparam int IOCTL_ADDR_WIDTH = 25;

    localparam logic [7:0] IOCTL_IDX_ROM  = 8'd0;
    localparam logic [7:0] IOCTL_IDX_ROM1 = 8'd1;
    localparam logic [7:0] IOCTL_IDX_NVR  = 8'd2;
    localparam logic [7:0] IOCTL_IDX_CFG  = 8'd254;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_FETCH,
        S_ISSUE,
        S_GAP,
        S_TRAIL
    } ioctl_drv_state_t;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ioctl_cycle_counter.sv
// Loadable down-counter that stops at zero; times LEAD, GAP and TRAIL.
module ioctl_cycle_counter #(
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ioctl_download_driver.sv
// MiSTer ioctl download transmitter: streams bytes from a valid/ready
// source into a core's ioctl port, honouring ioctl_wait.
module ioctl_download_driver
    import ioctl_pkg::*;
#(
    parameter int ADDR_WIDTH   = IOCTL_ADDR_WIDTH,
    parameter int LEAD_CYCLES  = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int TRAIL_CYCLES = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            index,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  abort,
    input  logic                  src_valid,
    input  logic [7:0]            src_data,
    output logic                  src_ready,
    output logic                  ioctl_download,
    output logic                  ioctl_wr,
    output logic [ADDR_WIDTH-1:0] ioctl_addr,
    output logic [7:0]            ioctl_dout,
    output logic [7:0]            ioctl_index,
    input  logic                  ioctl_wait,
    output logic                  busy,
    output logic                  done
);

    localparam int CW =
        $clog2(max3(LEAD_CYCLES, GAP_CYCLES, TRAIL_CYCLES)) + 1;

    ioctl_drv_state_t      r_state;
    logic [ADDR_WIDTH-1:0] r_len;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_byte;
    logic [7:0]            r_dout;
    logic [7:0]            r_index;
    logic                  r_ready;
    logic                  r_download;
    logic                  r_wr;
    logic                  r_busy;
    logic                  r_done;

    logic [ADDR_WIDTH-1:0] w_next;
    logic                  w_zero;
    logic                  w_load;
    logic [CW-1:0]         w_load_val;

    assign w_next = r_count + 1'b1;

    // Reload the shared timer on entry to each timed state
    always_comb begin
        w_load     = 1'b0;
        w_load_val = CW'(LEAD_CYCLES - 1);
        unique case (r_state)
            S_IDLE: w_load = start;
            S_ISSUE: begin
                w_load     = !ioctl_wait;
                w_load_val = CW'(GAP_CYCLES - 1);
            end
            S_GAP: begin
                w_load     = w_zero;
                w_load_val = CW'(TRAIL_CYCLES - 1);
            end
            default: w_load = 1'b0;
        endcase
    end

    ioctl_cycle_counter #(
        .WIDTH(CW)
    ) u_timer (
        .i_clk  (clk_sys),
        .i_reset(reset),
        .i_load (w_load),
        .i_value(w_load_val),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_count    <= '0;
            r_addr     <= '0;
            r_byte     <= '0;
            r_dout     <= '0;
            r_index    <= '0;
            r_ready    <= 1'b0;
            r_download <= 1'b0;
            r_wr       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            if (abort && r_state != S_IDLE) begin
                r_state    <= S_IDLE;
                r_ready    <= 1'b0;
                r_download <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            if (length != '0) begin
                                r_len      <= length;
                                r_index    <= index;
                                r_count    <= '0;
                                r_download <= 1'b1;
                                r_busy     <= 1'b1;
                                r_state    <= S_LEAD;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_LEAD: begin
                        if (w_zero) begin
                            r_ready <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (src_valid) begin
                            r_byte  <= src_data;
                            r_ready <= 1'b0;
                            r_state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (!ioctl_wait) begin
                            r_wr    <= 1'b1;
                            r_dout  <= r_byte;
                            r_addr  <= r_count;
                            r_state <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (w_zero) begin
                            r_count <= w_next;
                            if (w_next < r_len) begin
                                r_ready <= 1'b1;
                                r_state <= S_FETCH;
                            end else begin
                                r_state <= S_TRAIL;
                            end
                        end
                    end
                    S_TRAIL: begin
                        if (w_zero) begin
                            r_download <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign src_ready      = r_ready;
    assign ioctl_download = r_download;
    assign ioctl_wr       = r_wr;
    assign ioctl_addr     = r_addr;
    assign ioctl_dout     = r_dout;
    assign ioctl_index    = r_index;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule

// File: tb/tb_ioctl_download_driver.sv
// Randomised self-checking bench for ioctl_download_driver.
module tb_ioctl_download_driver;
    import ioctl_pkg::*;

    localparam int AW    = 25;
    localparam int LEAD  = 4;
    localparam int GAP   = 2;
    localparam int TRAIL = 4;
    localparam int PL    = 512;

    logic          clk_sys;
    logic          reset;
    logic          start;
    logic [7:0]    index;
    logic [AW-1:0] length;
    logic          abort;
    logic          src_valid;
    logic [7:0]    src_data;
    logic          src_ready;
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [7:0]    ioctl_index;
    logic          ioctl_wait;
    logic          busy;
    logic          done;

    ioctl_download_driver #(
        .ADDR_WIDTH  (AW),
        .LEAD_CYCLES (LEAD),
        .GAP_CYCLES  (GAP),
        .TRAIL_CYCLES(TRAIL)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .start         (start),
        .index         (index),
        .length        (length),
        .abort         (abort),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_ready     (src_ready),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_index   (ioctl_index),
        .ioctl_wait    (ioctl_wait),
        .busy          (busy),
        .done          (done)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int base        = 0;
    int dl_cnt      = 0;
    int exp_done    = 0;

    bit vpat[PL];
    bit wpat[PL];
    bit rdy_log[PL];

    logic [7:0]    src_q[$];
    logic [7:0]    exp_bytes[$];
    int            wr_c[$];
    logic [AW-1:0] wr_a[$];
    logic [7:0]    wr_d[$];
    int            done_c[$];
    int            exp_wr[$];

    // One clock: complete the pending handshake, then log what the DUT shows
    task automatic tick();
        logic hs;
        int   k;
        hs = src_valid && src_ready;
        @(posedge clk_sys);
        #1;
        if (hs && src_q.size() > 0) void'(src_q.pop_front());
        src_data = (src_q.size() > 0) ? src_q[0] : 8'h00;
        cyc++;
        k = cyc - base;
        if (k >= 0 && k < PL) begin
            src_valid  = vpat[k];
            ioctl_wait = wpat[k];
            rdy_log[k] = src_ready;
        end else begin
            src_valid  = 1'b1;
            ioctl_wait = 1'b0;
        end
        if (ioctl_wr) begin
            wr_c.push_back(k);
            wr_a.push_back(ioctl_addr);
            wr_d.push_back(ioctl_dout);
            vectors++;
            if (!ioctl_download) begin
                miscompares++;
                $display("FAIL wr_outside_window t=%0d dl=%0b want 1", k, ioctl_download);
            end
        end
        if (done) done_c.push_back(k);
        if (ioctl_download) dl_cnt++;
    endtask

    task automatic clear_pat();
        for (int i = 0; i < PL; i++) begin
            vpat[i]    = 1'b1;
            wpat[i]    = 1'b0;
            rdy_log[i] = 1'b0;
        end
    endtask

    task automatic load_src(int n);
        logic [7:0] b;
        src_q.delete();
        exp_bytes.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(1, 255));
            src_q.push_back(b);
            exp_bytes.push_back(b);
        end
    endtask

    task automatic launch(int n, logic [7:0] idx);
        src_data = (src_q.size() > 0) ? src_q[0] : 8'h00;
        length   = AW'(n);
        index    = idx;
        start    = 1'b1;
        base     = cyc + 1;
        wr_c.delete();
        wr_a.delete();
        wr_d.delete();
        done_c.delete();
        dl_cnt = 0;
        tick();
        start = 1'b0;
    endtask

    // Protocol-level timing: fetch waits for valid, issue waits for !wait,
    // strobe the cycle after issue, then GAP before the next fetch.
    task automatic model(int n);
        int t;
        int f;
        int i;
        exp_wr.delete();
        t = LEAD;
        for (int b = 0; b < n; b++) begin
            f = t;
            while (f < PL && !vpat[f]) f++;
            i = f + 1;
            while (i < PL && wpat[i]) i++;
            exp_wr.push_back(i + 1);
            t = i + 1 + GAP;
        end
        exp_done = t + TRAIL;
    endtask

    task automatic run_to_done(int budget);
        int n;
        n = 0;
        while (done_c.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (done_c.size() == 0) begin
            miscompares++;
            $display("FAIL done_timeout got none want done within %0d", budget);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if ({src_ready, ioctl_download, ioctl_wr, busy, done} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 00000",
                     {src_ready, ioctl_download, ioctl_wr, busy, done});
        end
        vectors++;
        if (ioctl_addr !== '0 || ioctl_dout !== 8'h00 || ioctl_index !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_buses got a=%0h d=%0h i=%0h want 0",
                     ioctl_addr, ioctl_dout, ioctl_index);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int et[3];
        et[0] = 6;
        et[1] = 10;
        et[2] = 14;
        clear_pat();
        src_q.delete();
        exp_bytes.delete();
        src_q = '{8'hA5, 8'h5A, 8'hFF};
        exp_bytes = '{8'hA5, 8'h5A, 8'hFF};
        launch(3, 8'h01);
        vectors++;
        if (ioctl_download !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_open got dl=%0b busy=%0b want 1 1", ioctl_download, busy);
        end
        run_to_done(100);
        vectors++;
        if (wr_c.size() != 3) begin
            miscompares++;
            $display("FAIL basic_count got %0d want 3", wr_c.size());
        end
        for (int b = 0; b < wr_c.size() && b < 3; b++) begin
            vectors++;
            if (wr_c[b] != et[b] || wr_a[b] !== AW'(b) || wr_d[b] !== exp_bytes[b]) begin
                miscompares++;
                $display("FAIL basic_wr%0d got t=%0d a=%0h d=%0h want t=%0d a=%0h d=%0h",
                         b, wr_c[b], wr_a[b], wr_d[b], et[b], b, exp_bytes[b]);
            end
        end
        vectors++;
        if (done_c.size() != 1 || done_c[0] != 20 || dl_cnt != 20) begin
            miscompares++;
            $display("FAIL basic_done got n=%0d dl=%0d want n=1 t=20 dl=20",
                     done_c.size(), dl_cnt);
        end
        vectors++;
        if (ioctl_addr !== AW'(2) || ioctl_dout !== 8'hFF || ioctl_index !== 8'h01) begin
            miscompares++;
            $display("FAIL basic_hold got a=%0h d=%0h i=%0h want 2 ff 01",
                     ioctl_addr, ioctl_dout, ioctl_index);
        end
    endtask

    task automatic test_backpressure();
        clear_pat();
        wpat[6] = 1'b1;
        wpat[7] = 1'b1;
        wpat[8] = 1'b1;
        for (int i = 9; i < 19; i++) wpat[i] = 1'b1;
        load_src(3);
        model(3);
        launch(3, IOCTL_IDX_ROM);
        run_to_done(100);
        vectors++;
        if (wr_c.size() != 3) begin
            miscompares++;
            $display("FAIL bp_count got %0d want 3", wr_c.size());
        end
        for (int b = 0; b < wr_c.size() && b < 3; b++) begin
            vectors++;
            if (wr_c[b] != exp_wr[b] || wr_a[b] !== AW'(b) || wr_d[b] !== exp_bytes[b]) begin
                miscompares++;
                $display("FAIL bp_wr%0d got t=%0d a=%0h d=%0h want t=%0d a=%0h d=%0h",
                         b, wr_c[b], wr_a[b], wr_d[b], exp_wr[b], b, exp_bytes[b]);
            end
        end
        vectors++;
        if (wr_c.size() > 1 && wr_c[1] != 20) begin
            miscompares++;
            $display("FAIL bp_delay got t=%0d want 20", wr_c[1]);
        end
        vectors++;
        if (done_c.size() != 1 || done_c[0] != exp_done) begin
            miscompares++;
            $display("FAIL bp_done got n=%0d want n=1 t=%0d", done_c.size(), exp_done);
        end
    endtask

    task automatic test_stall();
        int bad;
        clear_pat();
        for (int i = 8; i < 15; i++) vpat[i] = 1'b0;
        load_src(3);
        model(3);
        launch(3, 8'h02);
        run_to_done(100);
        bad = 0;
        for (int i = 8; i < 15; i++) if (!rdy_log[i]) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stall_ready got %0d low cycles want 0", bad);
        end
        vectors++;
        if (wr_c.size() != 3) begin
            miscompares++;
            $display("FAIL stall_count got %0d want 3", wr_c.size());
        end
        for (int b = 0; b < wr_c.size() && b < 3; b++) begin
            vectors++;
            if (wr_c[b] != exp_wr[b] || wr_a[b] !== AW'(b) || wr_d[b] !== exp_bytes[b]) begin
                miscompares++;
                $display("FAIL stall_wr%0d got t=%0d a=%0h d=%0h want t=%0d a=%0h d=%0h",
                         b, wr_c[b], wr_a[b], wr_d[b], exp_wr[b], b, exp_bytes[b]);
            end
        end
    endtask

    task automatic test_zero_length();
        clear_pat();
        src_q.delete();
        launch(0, 8'h03);
        vectors++;
        if (done !== 1'b1 || ioctl_download !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_pulse got done=%0b dl=%0b busy=%0b want 1 0 0",
                     done, ioctl_download, busy);
        end
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if (dl_cnt != 0 || done_c.size() != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_after got dl=%0d dones=%0d busy=%0b want 0 1 0",
                     dl_cnt, done_c.size(), busy);
        end
    endtask

    task automatic test_abort();
        int n;
        clear_pat();
        load_src(5);
        launch(5, 8'h04);
        n = 0;
        while (wr_c.size() < 2 && n < 60) begin
            tick();
            n++;
        end
        vectors++;
        if (wr_c.size() < 2) begin
            miscompares++;
            $display("FAIL abort_setup got %0d writes want 2", wr_c.size());
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if ({ioctl_download, ioctl_wr, busy, done, src_ready} !== 5'b0) begin
            miscompares++;
            $display("FAIL abort_next got %b want 00000",
                     {ioctl_download, ioctl_wr, busy, done, src_ready});
        end
        for (int i = 0; i < 25; i++) tick();
        vectors++;
        if (wr_c.size() != 2 || done_c.size() != 0) begin
            miscompares++;
            $display("FAIL abort_quiet got wr=%0d done=%0d want 2 0",
                     wr_c.size(), done_c.size());
        end
        load_src(2);
        model(2);
        launch(2, 8'h05);
        run_to_done(100);
        vectors++;
        if (wr_c.size() != 2 || wr_a[0] !== '0 || wr_d[0] !== exp_bytes[0]
            || wr_c[0] != exp_wr[0]) begin
            miscompares++;
            $display("FAIL abort_restart got n=%0d a0=%0h want n=2 a0=0",
                     wr_c.size(), (wr_a.size() > 0) ? wr_a[0] : '1);
        end
    endtask

    task automatic test_abort_start();
        abort  = 1'b1;
        start  = 1'b1;
        length = AW'(3);
        tick();
        abort = 1'b0;
        start = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || ioctl_download !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_start got busy=%0b dl=%0b done=%0b want 0 0 0",
                     busy, ioctl_download, done);
        end
    endtask

    task automatic test_reset_mid();
        clear_pat();
        load_src(3);
        launch(3, 8'h06);
        tick();
        reset = 1'b1;
        tick();
        vectors++;
        if ({src_ready, ioctl_download, ioctl_wr, busy, done, ioctl_addr,
             ioctl_dout, ioctl_index} !== '0) begin
            miscompares++;
            $display("FAIL reset_lead got dl=%0b busy=%0b a=%0h d=%0h i=%0h want 0",
                     ioctl_download, busy, ioctl_addr, ioctl_dout, ioctl_index);
        end
        reset = 1'b0;
        tick();
        clear_pat();
        for (int i = 9; i < 60; i++) wpat[i] = 1'b1;
        load_src(3);
        launch(3, 8'h07);
        for (int i = 0; i < 9; i++) tick();
        vectors++;
        if (ioctl_download !== 1'b1 || src_ready !== 1'b0 || ioctl_dout !== exp_bytes[0]) begin
            miscompares++;
            $display("FAIL issue_setup got dl=%0b rdy=%0b d=%0h want 1 0 %0h",
                     ioctl_download, src_ready, ioctl_dout, exp_bytes[0]);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if ({src_ready, ioctl_download, ioctl_wr, busy, done, ioctl_addr,
             ioctl_dout, ioctl_index} !== '0) begin
            miscompares++;
            $display("FAIL reset_issue got dl=%0b busy=%0b d=%0h i=%0h want 0",
                     ioctl_download, busy, ioctl_dout, ioctl_index);
        end
        reset = 1'b0;
        clear_pat();
        tick();
    endtask

    task automatic test_random();
        int         n;
        logic [7:0] idx;
        for (int it = 0; it < 8; it++) begin
            clear_pat();
            for (int i = 0; i < PL; i++) begin
                vpat[i] = ($urandom_range(0, 3) != 0);
                wpat[i] = ($urandom_range(0, 3) == 0);
            end
            n   = $urandom_range(1, 8);
            idx = 8'($urandom_range(0, 255));
            load_src(n);
            model(n);
            launch(n, idx);
            run_to_done(300);
            vectors++;
            if (wr_c.size() != n) begin
                miscompares++;
                $display("FAIL rnd%0d_count got %0d want %0d", it, wr_c.size(), n);
            end
            for (int b = 0; b < wr_c.size() && b < n; b++) begin
                vectors++;
                if (wr_c[b] != exp_wr[b] || wr_a[b] !== AW'(b) || wr_d[b] !== exp_bytes[b]) begin
                    miscompares++;
                    $display("FAIL rnd%0d_wr%0d got t=%0d a=%0h d=%0h want t=%0d a=%0h d=%0h",
                             it, b, wr_c[b], wr_a[b], wr_d[b], exp_wr[b], b, exp_bytes[b]);
                end
            end
            vectors++;
            if (done_c.size() != 1 || done_c[0] != exp_done || dl_cnt != exp_done
                || ioctl_index !== idx) begin
                miscompares++;
                $display("FAIL rnd%0d_done got n=%0d dl=%0d i=%0h want t=%0d dl=%0d i=%0h",
                         it, done_c.size(), dl_cnt, ioctl_index, exp_done, exp_done, idx);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        index      = 8'h00;
        length     = '0;
        src_valid  = 1'b0;
        src_data   = 8'h00;
        ioctl_wait = 1'b0;
        clear_pat();
        test_reset();
        test_basic();
        test_backpressure();
        test_stall();
        test_zero_length();
        test_abort();
        test_abort_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
